// File: rtl/mcu_sched_pkg.sv
// Shared types and constants for the MCU block scheduler.
package mcu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BLK = 2'd1,
    ST_XFER     = 2'd2
  } sched_state_t;

  localparam int BLK_BEATS = 64;

  typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/mcu_scheduler.sv
// Round-robin 8x8 block scheduler feeding one shared DCT/Huffman path, Y/Cb/Cr in fixed order.
// Optional stall statistic enabled by defining MCU_SCHED_STALL_CNT_EN.
module mcu_scheduler
  import mcu_sched_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  parameter int NUM_CH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_sync,
  input  logic [NUM_CH-1:0] blk_rdy,
  input  logic              coder_ready,
  output logic [NUM_CH-1:0] blk_take,
  output logic              rd_en,
  output logic [5:0]        rd_addr,
  output ch_idx_t           ch_sel,
  output logic              blk_start,
  output logic              blk_last,
  output logic              frame_start,
  output logic              frame_end,
  output logic [15:0]       stall_cnt
);

  localparam int          MCU_TOTAL = (WIDTH / 8) * (HEIGHT / 8);
  localparam logic [13:0] LAST_MCU  = 14'(MCU_TOTAL - 1);
  localparam ch_idx_t     LAST_CH   = ch_idx_t'(NUM_CH - 1);

  sched_state_t state_r;
  ch_idx_t      ch_r;
  logic [13:0]  mcu_r;
  logic [5:0]   beat_r;
  logic         take_s;
  logic         beat_last_s;
  logic         ch_last_s;
  logic         frame_last_s;

  // Claim strobe, read strobe and position decodes; a claim coinciding with frame_sync would be lost, so it is held off
  always_comb begin
    take_s       = 1'b0;
    rd_en        = 1'b0;
    beat_last_s  = (beat_r == 6'(BLK_BEATS - 1));
    ch_last_s    = (ch_r == LAST_CH);
    frame_last_s = ch_last_s && (mcu_r == LAST_MCU);
    if (state_r == ST_WAIT_BLK) begin
      take_s = blk_rdy[ch_r] && !frame_sync;
    end else if (state_r == ST_XFER) begin
      rd_en = coder_ready;
    end else begin
      take_s = 1'b0;
      rd_en  = 1'b0;
    end
  end

  assign blk_take    = take_s ? ({{(NUM_CH-1){1'b0}}, 1'b1} << ch_r) : {NUM_CH{1'b0}};
  assign rd_addr     = beat_r;
  assign ch_sel      = ch_r;
  assign blk_start   = rd_en && (beat_r == 6'd0);
  assign blk_last    = rd_en && beat_last_s;
  assign frame_start = blk_start && (ch_r == 2'd0) && (mcu_r == 14'd0);
  assign frame_end   = blk_last && frame_last_s && !frame_sync;

  // Scheduler FSM: frame_sync restarts the frame from any state and wins over a final beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ch_r    <= 2'd0;
      mcu_r   <= 14'd0;
      beat_r  <= 6'd0;
    end else if (frame_sync) begin
      state_r <= ST_WAIT_BLK;
      ch_r    <= 2'd0;
      mcu_r   <= 14'd0;
      beat_r  <= 6'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_WAIT_BLK: begin
          if (take_s) begin
            beat_r  <= 6'd0;
            state_r <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (rd_en) begin
            if (beat_last_s) begin
              beat_r <= 6'd0;
              if (frame_last_s) begin
                state_r <= ST_IDLE;
                ch_r    <= 2'd0;
                mcu_r   <= 14'd0;
              end else begin
                state_r <= ST_WAIT_BLK;
                if (ch_last_s) begin
                  ch_r  <= 2'd0;
                  mcu_r <= mcu_r + 14'd1;
                end else begin
                  ch_r <= ch_r + 2'd1;
                end
              end
            end else begin
              beat_r <= beat_r + 6'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MCU_SCHED_STALL_CNT_EN
  logic [15:0] stall_r;

  // Saturating count of transfer cycles lost to coder backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_r <= 16'd0;
    end else if (frame_sync) begin
      stall_r <= 16'd0;
    end else if ((state_r == ST_XFER) && !coder_ready && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cnt = stall_r;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mcu_scheduler.sv
// Directed self-checking bench for mcu_scheduler with a 16x8 frame (2 MCUs, 6 blocks).
module tb_mcu_scheduler;

  localparam int NCH    = 3;
  localparam int NBEATS = 384;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           frame_sync = 1'b0;
  logic           coder_ready = 1'b0;
  logic [NCH-1:0] blk_rdy = '0;
  logic [NCH-1:0] blk_take;
  logic           rd_en;
  logic [5:0]     rd_addr;
  logic [1:0]     ch_sel;
  logic           blk_start;
  logic           blk_last;
  logic           frame_start;
  logic           frame_end;
  logic [15:0]    stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int stalls;
  bit found;

  always #5 clk = ~clk;

  mcu_scheduler #(.WIDTH(16), .HEIGHT(8), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst), .frame_sync(frame_sync), .blk_rdy(blk_rdy),
    .coder_ready(coder_ready), .blk_take(blk_take), .rd_en(rd_en),
    .rd_addr(rd_addr), .ch_sel(ch_sel), .blk_start(blk_start),
    .blk_last(blk_last), .frame_start(frame_start), .frame_end(frame_end),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sync();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_take"}, 32'(blk_take), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_ch_sel"}, 32'(ch_sel), 32'd0);
    chk({tag, "_markers"}, 32'({blk_start, blk_last, frame_start, frame_end}), 32'd0);
    chk({tag, "_stall"}, 32'(stall_cnt), 32'd0);
  endtask

  // Runs one whole frame from the current point; mode 0 = coder always ready, 1 = ready every other cycle
  task automatic collect(input int mode, input int bound, output int stall_model);
    int  n    = 0;
    bit  prev = 1'b0;
    bit  done = 1'b0;
    bit  inx  = 1'b0;
    stall_model = 0;
    for (int c = 0; c < bound && !done; c++) begin
      coder_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      @(negedge clk);
      chk("take_onehot", 32'($countones(blk_take) <= 1), 32'd1);
      if (inx && !coder_ready) stall_model++;
      if (blk_take != '0) inx = 1'b1;
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), 32'(n % 64));
        chk("ch_sel", 32'(ch_sel), 32'((n / 64) % 3));
        chk("blk_start", 32'(blk_start), 32'((n % 64) == 0));
        chk("blk_last", 32'(blk_last), 32'((n % 64) == 63));
        chk("frame_start", 32'(frame_start), 32'(n == 0));
        chk("frame_end", 32'(frame_end), 32'(n == NBEATS - 1));
        if (mode == 0 && (n % 64) != 0) chk("contig", 32'(prev), 32'd1);
        if ((n % 64) == 63) inx = 1'b0;
        if (n == NBEATS - 1) done = 1'b1;
        n++;
      end else begin
        chk("quiet_markers", 32'({blk_start, blk_last, frame_start, frame_end}), 32'd0);
      end
      prev = rd_en;
      tick();
    end
    chk("beats_per_frame", 32'(n), 32'(NBEATS));
  endtask

  initial begin
    // Reset with everything ready: outputs must stay quiet
    blk_rdy     = 3'b111;
    coder_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst = 1'b0;

    // Full frame, no backpressure, then IDLE despite ready blocks
    pulse_sync();
    collect(0, 1000, stalls);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_frame_take", 32'(blk_take), 32'd0);
      chk("post_frame_rd", 32'(rd_en), 32'd0);
      tick();
    end

    // Coder ready every other cycle
    pulse_sync();
    collect(1, 2000, stalls);
`ifdef MCU_SCHED_STALL_CNT_EN
    chk("stall_toggle", 32'(stall_cnt), 32'(stalls));
`else
    chk("stall_toggle", 32'(stall_cnt), 32'd0);
`endif

    // Channel 1 not ready: strict order blocks channel 2
    blk_rdy     = 3'b101;
    coder_ready = 1'b1;
    pulse_sync();
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (rd_en && blk_last) found = 1'b1;
      tick();
    end
    chk("ch0_done", 32'(found), 32'd1);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("blocked_take", 32'(blk_take), 32'd0);
      chk("blocked_ch", 32'(ch_sel), 32'd1);
      chk("blocked_rd", 32'(rd_en), 32'd0);
      tick();
    end
    blk_rdy = 3'b111;
    @(negedge clk);
    chk("unblock_take", 32'(blk_take), 32'b010);
    tick();

    // Abort at beat 30 of channel 1
    pulse_sync();
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (rd_en && ch_sel == 2'd1 && rd_addr == 6'd30) begin
        found      = 1'b1;
        frame_sync = 1'b1;
      end
      tick();
    end
    frame_sync = 1'b0;
    chk("abort_point", 32'(found), 32'd1);
    @(negedge clk);
    chk("abort_ch", 32'(ch_sel), 32'd0);
    chk("abort_take", 32'(blk_take), 32'b001);
    chk("abort_rd", 32'(rd_en), 32'd0);
    chk("abort_fe", 32'(frame_end), 32'd0);
    tick();
    collect(0, 1000, stalls);

    // Reset in mid-transfer, then no resumption without frame_sync
    pulse_sync();
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 6'd10) found = 1'b1;
      else tick();
    end
    chk("reset_point", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("no_sync_take", 32'(blk_take), 32'd0);
      chk("no_sync_rd", 32'(rd_en), 32'd0);
      tick();
    end
    pulse_sync();
    @(negedge clk);
    chk("resume_take", 32'(blk_take), 32'b001);
    tick();

    // Heavy stalls
    pulse_sync();
    coder_ready = 1'b0;
    repeat (300) tick();
    @(negedge clk);
    chk("stall_heavy_rd", 32'(rd_en), 32'd0);
`ifdef MCU_SCHED_STALL_CNT_EN
    chk("stall_heavy", 32'(stall_cnt), 32'd299);
`else
    chk("stall_heavy", 32'(stall_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
